// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_id_e;

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: flags the cycle in which an unacknowledged transaction
// reaches TIMEOUT_CYCLES busy cycles. Only used when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // The count equals the number of busy cycles already spent, so expiry fires in busy cycle TIMEOUT_CYCLES.
  assign expire_o = busy_i & ~ack_i & (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = 8'd0;
    if (busy_i && !ack_i && !expire_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one memory bus, data-priority with one-shot fetch fairness.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort transactions lacking mem_ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wmask,
  output logic            dm_done,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            core_stall,
  output logic            err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic            if_done_q, if_done_d;
  logic            dm_done_q, dm_done_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            err_q, err_d;
  logic            fair_q, fair_d;
  logic            busy;
  logic            timeout;
  logic            if_go;
  logic            dm_go;
  port_id_e        owner;

  assign busy  = (state_q != IDLE);
  assign owner = (state_q == BUSY_DM) ? PORT_DM : PORT_IF;
  // Requesters drop req on their done pulse, so a req seen alongside done is stale.
  assign if_go = if_req & ~if_done_q;
  assign dm_go = dm_req & ~dm_done_q;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .busy_i   (busy),
    .ack_i    (mem_ack),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = 1'b0;
    fair_d     = fair_q;
    case (state_q)
      IDLE: begin
        // A fetch left waiting behind a data completion goes before the next data request.
        if (dm_go && !(fair_q && if_go)) begin
          state_d = BUSY_DM;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          wmask_d = dm_wmask;
          fair_d  = 1'b0;
        end else if (if_go) begin
          state_d = BUSY_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          fair_d  = 1'b0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack || timeout) begin
          state_d = IDLE;
          addr_d  = '0;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          err_d   = ~mem_ack;
          if (owner == PORT_DM) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = mem_ack ? mem_rdata : '0;
            fair_d     = if_req;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
      fair_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
      fair_q     <= fair_d;
    end
  end

  assign mem_req    = busy;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign if_done    = if_done_q;
  assign dm_done    = dm_done_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign err        = err_q;
  assign core_stall = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout scenario follows MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_wmask;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          core_stall;
  logic          err;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .core_stall(core_stall), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_wmask = '0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_wmask !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wr got we=%b mask=%h data=%h want 0", mem_we, mem_wmask, mem_wdata); end
    checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b%b want 00", if_done, dm_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h/%h want 0/0", if_rdata, dm_rdata); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", core_stall); end
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got %b want 0", mem_req); end
  endtask

  task automatic test_zero_wait_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("[TB] FAIL zw_stall_req got %b want 1", core_stall); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL zw_grant got req=%b addr=%h want 1/00000010", mem_req, mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_wmask !== 4'h0) begin errors++; $display("[TB] FAIL zw_fetch_rd got we=%b mask=%h want 0/0", mem_we, mem_wmask); end
    checks++; if (if_done !== 1'b0) begin errors++; $display("[TB] FAIL zw_early_done got %b want 0", if_done); end
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    step();
    checks++; if (if_done !== 1'b1) begin errors++; $display("[TB] FAIL zw_done got %b want 1", if_done); end
    checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("[TB] FAIL zw_rdata got %h want 00500093", if_rdata); end
    checks++; if (mem_req !== 1'b0 || core_stall !== 1'b0) begin errors++; $display("[TB] FAIL zw_release got req=%b stall=%b want 0/0", mem_req, core_stall); end
    if_req = 1'b0; mem_ack = 1'b0;
    step();
    checks++; if (if_done !== 1'b0 || if_rdata !== 32'h00500093) begin errors++; $display("[TB] FAIL zw_hold got done=%b rdata=%h want 0/00500093", if_done, if_rdata); end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_wmask = 4'hF;
    step();
    checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL sim_dm_first got addr=%h we=%b want 00000100/1", mem_addr, mem_we); end
    checks++; if (mem_wdata !== 32'hDEADBEEF || mem_wmask !== 4'hF) begin errors++; $display("[TB] FAIL sim_store_data got %h/%h want deadbeef/f", mem_wdata, mem_wmask); end
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    checks++; if (dm_done !== 1'b1 || if_done !== 1'b0) begin errors++; $display("[TB] FAIL sim_dm_done got dm=%b if=%b want 1/0", dm_done, if_done); end
    dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = '0; dm_wmask = 4'h0; mem_ack = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sim_fetch_next got req=%b addr=%h we=%b want 1/00000020/0", mem_req, mem_addr, mem_we); end
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    step();
    checks++; if (if_done !== 1'b1 || if_rdata !== 32'h11112222) begin errors++; $display("[TB] FAIL sim_fetch_done got %b/%h want 1/11112222", if_done, if_rdata); end
    checks++; if (core_stall !== 1'b1) begin errors++; $display("[TB] FAIL sim_dm_stall got %b want 1", core_stall); end
    if_req = 1'b0; mem_ack = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sim_dm_after got req=%b addr=%h we=%b want 1/00000200/0", mem_req, mem_addr, mem_we); end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    checks++; if (dm_done !== 1'b1 || dm_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL sim_load_done got %b/%h want 1/12345678", dm_done, dm_rdata); end
    dm_req = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_wait_states();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("[TB] FAIL ws_stall_c1 got %b want 1", core_stall); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin errors++; $display("[TB] FAIL ws_addr_%0d got req=%b addr=%h want 1/00000104", i, mem_req, mem_addr); end
      checks++; if (dm_done !== 1'b0 || core_stall !== 1'b1) begin errors++; $display("[TB] FAIL ws_busy_%0d got done=%b stall=%b want 0/1", i, dm_done, core_stall); end
      if (i == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      end
    end
    step();
    checks++; if (dm_done !== 1'b1 || dm_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL ws_done got %b/%h want 1/cafef00d", dm_done, dm_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ws_release got %b want 0", mem_req); end
    dm_req = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_busy();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rb_grant got %b want 1", mem_req); end
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rb_async got req=%b addr=%h want 0/0", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk);
    #1;
    checks++; if (dm_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rb_no_done got done=%b req=%b want 0/0", dm_done, mem_req); end
    rst = 1'b1; mem_ack = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("[TB] FAIL rb_regrant got req=%b addr=%h want 1/00000300", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    checks++; if (dm_done !== 1'b1 || dm_rdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rb_done got %b/%h want 1/0badf00d", dm_done, dm_rdata); end
    dm_req = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    step();
    checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("[TB] FAIL stray_done got %b%b want 00", if_done, dm_done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL stray_state got %b want 0", mem_req); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL stray_rdata got %h/%h want 0/0badf00d", if_rdata, dm_rdata); end
    mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h30;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h30) begin errors++; $display("[TB] FAIL stray_after got req=%b addr=%h want 1/00000030", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h13572468;
    step();
    checks++; if (if_done !== 1'b1 || if_rdata !== 32'h13572468) begin errors++; $display("[TB] FAIL stray_fetch got %b/%h want 1/13572468", if_done, if_rdata); end
    if_req = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 32'h40;
    step();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      checks++; if (mem_req !== 1'b1 || err !== 1'b0 || if_done !== 1'b0) begin errors++; $display("[TB] FAIL to_busy_%0d got req=%b err=%b done=%b want 1/0/0", i, mem_req, err, if_done); end
      step();
    end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_drop got %b want 0", mem_req); end
    checks++; if (err !== 1'b1 || if_done !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse got err=%b done=%b want 1/1", err, if_done); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL to_rdata got %h want 0", if_rdata); end
    if_req = 1'b0;
    step();
    checks++; if (err !== 1'b0 || if_done !== 1'b0) begin errors++; $display("[TB] FAIL to_one_cycle got err=%b done=%b want 0/0", err, if_done); end
`else
    for (int i = 1; i <= 110; i++) begin
      checks++; if (mem_req !== 1'b1 || err !== 1'b0 || if_done !== 1'b0) begin errors++; $display("[TB] FAIL nt_wait_%0d got req=%b err=%b done=%b want 1/0/0", i, mem_req, err, if_done); end
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    step();
    checks++; if (if_done !== 1'b1 || if_rdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL nt_late_ack got %b/%h want 1/a5a5a5a5", if_done, if_rdata); end
    if_req = 1'b0; mem_ack = 1'b0;
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait_fetch();
    test_simultaneous();
    test_wait_states();
    test_reset_busy();
    test_stray_ack();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, 32, address width in bits.
REQ-002 The block SHALL have parameter DW, 32, data width in bits.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, 15, maximum cycles to wait for mem_ack (range 1..255).
REQ-004 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port if_req / if_addr, input, 1 / AW, instruction-fetch request and word address.
REQ-007 The block SHALL have port if_done / if_rdata, output, 1 / DW, fetch completion pulse and fetched word.
REQ-008 The block SHALL have port dm_req / dm_we / dm_addr / dm_wdata / dm_wmask, input, 1 / 1 / AW / DW / DW/8, data load/store request.
REQ-009 The block SHALL have port dm_done / dm_rdata, output, 1 / DW, data completion pulse and load data.
REQ-010 The block SHALL have port mem_req / mem_we / mem_addr / mem_wdata / mem_wmask, output, 1 / 1 / AW / DW / DW/8, shared memory request.
REQ-011 The block SHALL have port mem_ack / mem_rdata, input, 1 / DW, memory acknowledge and read data.
REQ-012 The block SHALL have port core_stall, output, 1, high while any request is pending and not done.
REQ-013 The block SHALL have port err, output, 1, one-cycle pulse marking a timed-out transaction.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY_IF and BUSY_DM.
REQ-015 In IDLE with dm_req high, the block SHALL enter BUSY_DM; with only if_req high, it SHALL enter BUSY_IF, so data has fixed priority over fetch.
REQ-016 On grant, the block SHALL register the granted port's address, we, wdata and wmask and drive them on mem_* unchanged until the transaction ends; fetch drives mem_we=0 and wmask=0.
REQ-017 mem_req SHALL be high exactly while in BUSY_IF or BUSY_DM.
REQ-018 On mem_ack high in BUSY_x, the block SHALL register mem_rdata into x_rdata, pulse x_done for one cycle on the next cycle, and return to IDLE.
REQ-019 Minimum latency: req sampled at edge N, mem_req high after N, ack sampled at N+1, done high after N+1; a zero-wait memory gives 2 cycles per transaction.
REQ-020 x_rdata SHALL hold its value until the next completion on that port; dm_rdata SHALL be updated for stores as well (value don't-care).
REQ-021 The block SHALL ignore a port's req in any cycle where that port's done is high, because the requester drops req on done.
REQ-022 If both requests are pending after a data completion, the block SHALL grant fetch before accepting a new data request, a one-shot fairness rule that prevents fetch starvation.
REQ-023 core_stall SHALL equal (if_req & ~if_done) | (dm_req & ~dm_done), purely combinational.
REQ-024 mem_ack in IDLE SHALL be ignored.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, mem_req=0, all mem_* outputs=0, if_done=dm_done=0, err=0, if_rdata=dm_rdata=0, fairness flag=0 and timeout count=0.
REQ-026 Reset mid-transaction SHALL abandon it with no done pulse; the first grant SHALL occur on the first edge with rst high.

Configuration
REQ-027 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL run while BUSY; if it reaches TIMEOUT_CYCLES without mem_ack, the block SHALL drop mem_req, pulse the owner's done and err together, load rdata with 0, and return to IDLE.
REQ-028 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait indefinitely for mem_ack, with err tied to 0 and no counter logic.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum, the port-id enum (PORT_IF, PORT_DM) and the default AW/DW constants.
REQ-030 Sub-module mem_arb_wdog SHALL implement the timeout counter and SHALL be instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-031 The bench SHALL cover a zero-wait fetch: if_req, if_addr=0x10, mem_ack same cycle as mem_req, mem_rdata=0x00500093 -> if_done pulses 2 cycles after req, with if_rdata=0x00500093.
REQ-032 The bench SHALL cover simultaneous requests: if_req and dm_req (store 0xDEADBEEF to 0x100, wmask=0xF) -> dm granted first with mem_we=1, then fetch; a new dm_req waits one fetch.
REQ-033 The bench SHALL cover wait states: 3-cycle delayed mem_ack on load 0x104 -> mem_addr stable for 4 cycles, dm_done at cycle 5, core_stall high in cycles 1..4.
REQ-034 The bench SHALL cover reset in BUSY_DM: rst low for 1 cycle -> mem_req=0 immediately, no dm_done; re-request granted after release.
REQ-035 The bench SHALL cover timeout with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=15: no mem_ack -> err and if_done pulse after 15 busy cycles with if_rdata=0; with the macro undefined, mem_req stays high beyond 100 cycles.
REQ-036 The bench SHALL cover a stray mem_ack in IDLE -> no done, no state change.
